// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit saturating
// counter encoding and its update rule.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_ST) res = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: two combinational read ports (fetch lookup and
// EX/MEM update) and one synchronous write port.
module btb_array
    import bp_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 10,
    localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_a_idx,
    output logic             rd_a_valid,
    output logic [TAG_W-1:0] rd_a_tag,
    output logic [XLEN-1:0]  rd_a_target,
    output ctr_t             rd_a_ctr,
    input  logic [IDX_W-1:0] rd_b_idx,
    output logic             rd_b_valid,
    output logic [TAG_W-1:0] rd_b_tag,
    output logic [XLEN-1:0]  rd_b_target,
    output ctr_t             rd_b_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [XLEN-1:0]  wr_target,
    input  ctr_t             wr_ctr
);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        ctr_t             ctr;
    } entry_t;

    entry_t mem_q [ENTRIES];
    entry_t mem_d [ENTRIES];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = '{valid: 1'b1, tag: wr_tag, target: wr_target, ctr: wr_ctr};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_a_valid  = mem_q[rd_a_idx].valid;
        rd_a_tag    = mem_q[rd_a_idx].tag;
        rd_a_target = mem_q[rd_a_idx].target;
        rd_a_ctr    = mem_q[rd_a_idx].ctr;
        rd_b_valid  = mem_q[rd_b_idx].valid;
        rd_b_tag    = mem_q[rd_b_idx].tag;
        rd_b_target = mem_q[rd_b_idx].target;
        rd_b_ctr    = mem_q[rd_b_idx].ctr;
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB lookup from IF, update and mispredict
// resolution from EX/MEM, plus saturating branch/mispredict counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 10,
    parameter int unsigned MODE    = 1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic        DYN   = (MODE != 0);

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;

    logic             lk_valid, up_valid_e;
    logic [TAG_W-1:0] lk_etag, up_etag;
    logic [XLEN-1:0]  lk_target, up_etarget;
    ctr_t             lk_ctr, up_ctr;

    logic             lk_hit, up_hit;
    logic             wr_en;
    logic [XLEN-1:0]  wr_target;
    ctr_t             wr_ctr;
    logic             upd_fire;

    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    btb_array #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk         (clk),
        .reset       (reset),
        .rd_a_idx    (lk_idx),
        .rd_a_valid  (lk_valid),
        .rd_a_tag    (lk_etag),
        .rd_a_target (lk_target),
        .rd_a_ctr    (lk_ctr),
        .rd_b_idx    (up_idx),
        .rd_b_valid  (up_valid_e),
        .rd_b_tag    (up_etag),
        .rd_b_target (up_etarget),
        .rd_b_ctr    (up_ctr),
        .wr_en       (wr_en),
        .wr_idx      (up_idx),
        .wr_tag      (up_tag),
        .wr_target   (wr_target),
        .wr_ctr      (wr_ctr)
    );

    // Lookup sees the pre-update array state; there is no write bypass.
    always_comb begin
        lk_hit      = lk_valid && (lk_etag == lk_tag);
        pred_taken  = DYN && lk_hit && lk_ctr[1];
        pred_target = pred_taken ? lk_target : lookup_pc + XLEN'(4);
    end

    always_comb begin
        mispredict  = upd_valid && ((upd_pred_taken != upd_taken) ||
                                    (upd_taken && (upd_pred_target != upd_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
    end

    always_comb begin
        upd_fire  = upd_valid && !stall;
        up_hit    = up_valid_e && (up_etag == up_tag);
        wr_en     = 1'b0;
        wr_target = up_etarget;
        wr_ctr    = up_ctr;
        if (DYN && upd_fire) begin
            if (up_hit) begin
                wr_en  = 1'b1;
                wr_ctr = sat_update(up_ctr, upd_taken);
                if (upd_taken) wr_target = upd_target;
            end else if (upd_taken) begin
                // Allocation evicts whatever occupied this index.
                wr_en     = 1'b1;
                wr_target = upd_target;
                wr_ctr    = CTR_WT;
            end
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_fire && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (mispredict && !stall && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispred_cnt_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage pipeline. It replaces the fixed "predict not-taken, resolve in MEM" path that drives the PC mux.
- Direct-mapped branch target buffer (BTB). Each entry holds a valid bit, a tag, a target and a 2-bit saturating counter.
- Lookup is combinational from the IF-stage PC. Update and mispredict resolution are driven from the EX/MEM latch.
- Keeps saturating performance counters for branches and mispredicts.

Parameters:
- XLEN, 64, PC and target width.
- ENTRIES, 16, number of BTB entries; must be a power of 2 and at least 2.
- TAG_W, 10, tag width. The tag is taken from the PC bits directly above the index.
- MODE, 1, prediction mode: 0 = static not-taken (never allocates, pred_taken always 0); 1 = dynamic 2-bit.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  pipeline stall; blocks updates and counter increments.
- lookup_pc  in  XLEN  PC of the instruction being fetched.
- pred_taken  out  1  prediction for lookup_pc.
- pred_target  out  XLEN  predicted target; equals lookup_pc+4 when pred_taken=0.
- upd_valid  in  1  a resolved conditional branch is present in EX/MEM.
- upd_pc  in  XLEN  PC of the resolved branch.
- upd_taken  in  1  actual outcome of the branch.
- upd_target  in  XLEN  actual taken target (the adder output).
- upd_pred_taken  in  1  prediction made for this branch, carried down the pipeline.
- upd_pred_target  in  XLEN  predicted target, carried down the pipeline.
- mispredict  out  1  flush request.
- redirect_pc  out  XLEN  correct next PC, used when mispredict=1.
- branch_count  out  CNT_W  number of resolved branches.
- mispredict_count  out  CNT_W  number of mispredicts.

Behaviour:
- Field definitions:
  - IDX_W = log2(ENTRIES).
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - PC bits [1:0] are ignored.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - pred_taken = MODE && hit && ctr[idx][1].
  - pred_target = pred_taken ? btb_target[idx] : lookup_pc+4. Addition wraps modulo 2^XLEN.
- Mispredict (combinational, qualified by upd_valid):
  - mispredict = upd_valid && ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - mispredict is asserted even when stall=1. The flush path has priority.
- Update (registered, applied at the clock edge where upd_valid=1 and stall=0):
  - Hit, taken: ctr increments, saturating at 11; target is written with upd_target.
  - Hit, not taken: ctr decrements, saturating at 00; target is unchanged.
  - Miss, taken, MODE=1: allocate the entry (overwrite it even if valid with a different tag). Set valid=1, tag=upd tag, target=upd_target, ctr=10 (weakly taken).
  - Miss, not taken: no change.
  - MODE=0: the BTB array is never written.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Same-cycle lookup and update of the same index: lookup returns the pre-update state. There is no bypass.
- Performance counters:
  - branch_count increments on each upd_valid && !stall edge.
  - mispredict_count increments on each mispredict && !stall edge.
  - Both saturate at all-ones and do not wrap.
- Reset (reset=0 at a clock edge):
  - All valid bits cleared, all ctr set to 01, targets and tags set to 0, both perf counters set to 0.
  - Resulting outputs: pred_taken=0, pred_target=lookup_pc+4, branch_count=0, mispredict_count=0.
  - mispredict and redirect_pc still follow their inputs combinationally.
- Reset mid-operation: reset takes priority over an update in the same cycle; the update is discarded.

Decomposition:
- Shared package (e.g. bp_pkg):
  - typedef for the 2-bit counter with constants CTR_SNT, CTR_WNT, CTR_WT, CTR_ST.
  - typedef for the BTB entry struct {valid, tag, target, ctr}.
  - function sat_update(ctr, taken).
- One sub-module, btb_array: the storage array, with a combinational read port and a synchronous write port.
- The top level owns hit detection, prediction, mispredict logic and the performance counters.

Test Plan:
- Reset, then lookup_pc=0x100 -> pred_taken=0, pred_target=0x104; both counters 0.
- Update pc=0x100, taken=1, target=0x40, pred_taken=0 -> mispredict=1, redirect_pc=0x40. Next cycle, lookup 0x100 -> pred_taken=1, pred_target=0x40; mispredict_count=1.
- Three taken updates at 0x100, then two not-taken (with correct pred fields) -> ctr goes 10->11->11->10->01. After the second not-taken, pred_taken=0 and the entry stays valid.
- Aliasing with ENTRIES=16, TAG_W=10: allocate 0x100 taken, then a taken update at 0x140 (same index, different tag) -> lookup 0x100 misses (pred 0x104); lookup 0x140 hits with the new target.
- upd_valid=1 with stall=1 -> mispredict still asserted, BTB unchanged, branch_count unchanged. Update coincident with reset=0 -> entry not allocated.
- MODE=0: taken updates at 0x200 -> pred_taken always 0, mispredict=1 on every taken branch, mispredict_count increments each time.
